// File: rtl/mcu_bus_ctrl_if.sv
// Strobe and address pins of the microcontroller's multiplexed bus.
// The data bus stays a top-level inout so it resolves as a plain net.
interface mcu_bus_ctrl_if;
    logic       ALE;
    logic       CSbar;
    logic       Rbar;
    logic       Wbar;
    logic [7:0] ABUS;

    modport master (output ALE, CSbar, Rbar, Wbar, ABUS);
    modport slave  (input  ALE, CSbar, Rbar, Wbar, ABUS);
endinterface

// File: rtl/mcu_bus_ctrl.sv
// Slave controller for the MCU address/data bus and its register file.
// Define MCU_BUS_READBACK_EN to enable read cycles that drive DBUS.
module mcu_bus_ctrl #(
    parameter logic [7:0] RST_DIGIT = 8'd10
) (
    input  logic          clock,
    input  logic          reset,
    mcu_bus_ctrl_if.slave bus,
    inout  wire  [7:0]    DBUS,
    output logic [55:0]   b_regs,
    output logic [7:0]    operand,
    output logic [7:0]    hour,
    output logic [7:0]    minute,
    output logic          time_load,
    input  logic          time_ack,
    output logic          wr_err
);

    typedef enum logic [2:0] {
        IDLE, ADDR, WRITE, READ, HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  sync1, sync2;
    logic [2:0]  sync3;
    logic [7:0]  abus1, abus2;
    logic [7:0]  addr_q;
    logic [7:0]  b_q [0:6];
    logic        upd_t;

    logic ale_s, cs_s, rd_s, wr_s;
    logic wr_fall, rd_fall, cs_rise;
    logic wr_en;

    // bit order {ALE, CSbar, Rbar, Wbar}; ABUS rides along with ALE
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 4'b0111;
            sync2 <= 4'b0111;
            sync3 <= 3'b111;
            abus1 <= '0;
            abus2 <= '0;
        end else begin
            sync1 <= {bus.ALE, bus.CSbar, bus.Rbar, bus.Wbar};
            sync2 <= sync1;
            sync3 <= sync2[2:0];
            abus1 <= bus.ABUS;
            abus2 <= abus1;
        end
    end

    assign ale_s   = sync2[3];
    assign cs_s    = sync2[2];
    assign rd_s    = sync2[1];
    assign wr_s    = sync2[0];
    assign wr_fall = ~wr_s & sync3[0];
    assign rd_fall = ~rd_s & sync3[1];
    assign cs_rise = cs_s & ~sync3[2];

`ifdef MCU_BUS_READBACK_EN
    logic rd_rise;
    assign rd_rise = rd_s & ~sync3[1];
`endif

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ale_s) state_d = ADDR;
            ADDR: begin
                if (!cs_s && wr_fall && rd_fall)
                    state_d = HOLD;
                else if (!cs_s && wr_fall)
                    state_d = WRITE;
                else if (!cs_s && rd_fall)
`ifdef MCU_BUS_READBACK_EN
                    state_d = READ;
`else
                    state_d = HOLD;
`endif
            end
            WRITE: state_d = cs_rise ? IDLE : HOLD;
`ifdef MCU_BUS_READBACK_EN
            READ: if (cs_rise || rd_rise) state_d = IDLE;
`else
            READ: state_d = IDLE;
`endif
            HOLD: if (cs_rise || (wr_s && rd_s)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wr_en = (state_q == WRITE) && !cs_rise;

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q    <= '0;
            operand   <= '0;
            hour      <= '0;
            minute    <= '0;
            time_load <= 1'b0;
            wr_err    <= 1'b0;
            upd_t     <= 1'b0;
            for (int i = 0; i < 7; i++) b_q[i] <= RST_DIGIT;
        end else begin
            if (ale_s && (state_q == IDLE || state_q == ADDR))
                addr_q <= abus2;
            upd_t <= 1'b0;
            if (wr_en) begin
                unique case (1'b1)
                    (addr_q < 8'd7): b_q[addr_q[2:0]] <= DBUS;
                    (addr_q == 8'd7): operand <= DBUS;
                    (addr_q == 8'd8): begin
                        if (DBUS <= 8'd23) begin
                            hour  <= DBUS;
                            upd_t <= 1'b1;
                        end else wr_err <= 1'b1;
                    end
                    (addr_q == 8'd9): begin
                        if (DBUS <= 8'd59) begin
                            minute <= DBUS;
                            upd_t  <= 1'b1;
                        end else wr_err <= 1'b1;
                    end
                    default: wr_err <= 1'b1;
                endcase
            end
            // a fresh update outranks an ack landing in the same cycle
            if (upd_t)         time_load <= 1'b1;
            else if (time_ack) time_load <= 1'b0;
        end
    end

    always_comb begin
        b_regs = '0;
        for (int i = 0; i < 7; i++) b_regs[i*8 +: 8] = b_q[i];
    end

`ifdef MCU_BUS_READBACK_EN
    logic [7:0] rd_data;
    logic       dbus_oe;

    always_comb begin
        rd_data = 8'hFF;
        unique case (1'b1)
            (addr_q < 8'd7):  rd_data = b_q[addr_q[2:0]];
            (addr_q == 8'd7): rd_data = operand;
            (addr_q == 8'd8): rd_data = hour;
            (addr_q == 8'd9): rd_data = minute;
            default:          rd_data = 8'hFF;
        endcase
    end

    assign dbus_oe = !reset && state_q == READ && !rd_s && !cs_s;
    assign DBUS    = dbus_oe ? rd_data : 8'hzz;
`else
    assign DBUS = 8'hzz;
`endif

endmodule
